pll_seq: RTL and testbench

- Sequencer sitting in front of the digital PLL, clocked by refclk.
- Drives the PLL's resetn, brake and divn inputs; consumes a registered lock indication from the PLL lock detector.
- Performs power-up bring-up with lock timeout and retry.
- Accepts divider retarget requests over a valid/ready handshake and glides divn stepwise to the new value; converts supply-droop requests into timed brake pulses.
- Reports locked/busy/fault status and a loss-of-lock counter.

---
 rtl/pll_seq_if.sv | 12 +
 rtl/pll_seq.sv | 196 +++++++++++++++++++
 tb/tb_pll_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_if.sv
// Divider retarget request channel between a controller and the PLL sequencer.
// The master drives a target divider word; the sequencer accepts it on valid & ready.
interface pll_seq_if #(
  parameter int DIVN_W = 16
) ();
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIVN_W-1:0] cfg_divn;

  modport master (output cfg_valid, output cfg_divn, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_divn, output cfg_ready);
endinterface

// File: rtl/pll_seq.sv
// PLL bring-up / retarget / brake sequencer clocked by refclk.
// Holds the PLL in reset, waits for confirmed lock with retry, glides divn and pulses brake.
module pll_seq #(
  parameter int DIVN_W       = 16,
  parameter int DIVN_RESET   = 10,
  parameter int DIVN_MIN     = 4,
  parameter int RESET_CYCLES = 8,
  parameter int LOCK_CONFIRM = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int STEP         = 1,
  parameter int STEP_HOLD    = 32,
  parameter int BRAKE_PULSE  = 4
) (
  input  logic              refclk,
  input  logic              resetn,
  pll_seq_if.slave          cfg,
  input  logic              droop_req,
  input  logic              pll_locked,
  output logic              pll_resetn,
  output logic              pll_brake,
  output logic [DIVN_W-1:0] pll_divn,
  output logic              locked,
  output logic              busy,
  output logic              fault,
  output logic [7:0]        lol_count
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > RESET_CYCLES) ?
                           ((LOCK_TIMEOUT > STEP_HOLD) ? ((LOCK_TIMEOUT > BRAKE_PULSE) ? LOCK_TIMEOUT : BRAKE_PULSE)
                                                       : ((STEP_HOLD > BRAKE_PULSE) ? STEP_HOLD : BRAKE_PULSE))
                         : ((RESET_CYCLES > STEP_HOLD) ? ((RESET_CYCLES > BRAKE_PULSE) ? RESET_CYCLES : BRAKE_PULSE)
                                                       : ((STEP_HOLD > BRAKE_PULSE) ? STEP_HOLD : BRAKE_PULSE));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CONF_W  = $clog2(LOCK_CONFIRM + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_WAIT_LOCK,
    S_LOCKED,
    S_RAMP,
    S_BRAKE,
    S_FAULT
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [CONF_W-1:0]   confirm, confirm_d, confirm_inc;
  logic [RETRY_W-1:0]  retry, retry_d, retry_inc;
  logic [DIVN_W-1:0]   target, target_d, divn_d, req_divn;
  logic [DIVN_W-1:0]   step_gap, step_amt, ramp_next;
  logic                step_up;
  logic [7:0]          lol_d;
  logic                droop_req_q, droop_rise, fire;

  assign droop_rise    = droop_req & ~droop_req_q;
  assign cfg.cfg_ready = ((state == S_LOCKED) || (state == S_FAULT)) && !droop_rise;
  assign fire          = cfg.cfg_valid && cfg.cfg_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    confirm_d = confirm;
    retry_d   = retry;
    target_d  = target;
    divn_d    = pll_divn;
    lol_d     = lol_count;

    confirm_inc = confirm + CONF_W'(1);
    retry_inc   = retry + RETRY_W'(1);
    req_divn    = (cfg.cfg_divn < DIVN_W'(DIVN_MIN)) ? DIVN_W'(DIVN_MIN) : cfg.cfg_divn;
    step_up     = target > pll_divn;
    step_gap    = step_up ? (target - pll_divn) : (pll_divn - target);
    step_amt    = (step_gap < DIVN_W'(STEP)) ? step_gap : DIVN_W'(STEP);
    ramp_next   = step_up ? (pll_divn + step_amt) : (pll_divn - step_amt);

    case (state)
      S_RESET_HOLD: begin
        if (cnt == CNT_W'(1)) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = CNT_W'(LOCK_TIMEOUT);
          confirm_d = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        confirm_d = pll_locked ? confirm_inc : '0;
        // A lock confirmed on the last timeout cycle still wins.
        if (pll_locked && (confirm_inc == CONF_W'(LOCK_CONFIRM))) begin
          state_d = S_LOCKED;
          retry_d = '0;
        end else if (cnt == CNT_W'(1)) begin
          retry_d = retry_inc;
          if (retry_inc < RETRY_W'(MAX_RETRY)) begin
            state_d = S_RESET_HOLD;
            cnt_d   = CNT_W'(RESET_CYCLES);
          end else begin
            state_d = S_FAULT;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_LOCKED: begin
        if (droop_rise) begin
          state_d = S_BRAKE;
          cnt_d   = CNT_W'(BRAKE_PULSE);
        end else if (!pll_locked) begin
          lol_d     = (lol_count == 8'hFF) ? lol_count : lol_count + 8'd1;
          state_d   = S_WAIT_LOCK;
          cnt_d     = CNT_W'(LOCK_TIMEOUT);
          confirm_d = '0;
        end else if (fire) begin
          target_d = req_divn;
          if (req_divn != pll_divn) begin
            state_d = S_RAMP;
            cnt_d   = CNT_W'(STEP_HOLD);
          end
        end
      end
      S_RAMP: begin
        if (droop_rise) begin
          state_d = S_BRAKE;
          cnt_d   = CNT_W'(BRAKE_PULSE);
        end else if (cnt == CNT_W'(1)) begin
          divn_d = ramp_next;
          cnt_d  = CNT_W'(STEP_HOLD);
          if (ramp_next == target) begin
            state_d   = S_WAIT_LOCK;
            cnt_d     = CNT_W'(LOCK_TIMEOUT);
            confirm_d = '0;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_BRAKE: begin
        if (cnt == CNT_W'(1)) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = CNT_W'(LOCK_TIMEOUT);
          confirm_d = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_FAULT: begin
        if (fire) begin
          divn_d  = req_divn;
          retry_d = '0;
          state_d = S_RESET_HOLD;
          cnt_d   = CNT_W'(RESET_CYCLES);
        end
      end
      default: state_d = S_RESET_HOLD;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: this block holds only flops (no storage array), so each one gets an async reset value.
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_RESET_HOLD;
      cnt         <= CNT_W'(RESET_CYCLES);
      confirm     <= '0;
      retry       <= '0;
      target      <= DIVN_W'(DIVN_RESET);
      pll_divn    <= DIVN_W'(DIVN_RESET);
      lol_count   <= '0;
      droop_req_q <= 1'b0;
      pll_resetn  <= 1'b0;
      pll_brake   <= 1'b0;
      locked      <= 1'b0;
      busy        <= 1'b1;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      confirm     <= confirm_d;
      retry       <= retry_d;
      target      <= target_d;
      pll_divn    <= divn_d;
      lol_count   <= lol_d;
      droop_req_q <= droop_req;
      // Status pins are decoded from the next state so they change with it.
      pll_resetn  <= !(state_d inside {S_RESET_HOLD, S_FAULT});
      pll_brake   <= (state_d == S_BRAKE);
      locked      <= (state_d == S_LOCKED);
      busy        <= !(state_d inside {S_LOCKED, S_FAULT});
      fault       <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_seq.sv
// Self-checking bench for pll_seq: a phase/elapsed-time model checked every cycle,
// plus directed scenarios with hand-computed cycle counts and values.
module tb_pll_seq;

  localparam int DIVN_W = 16;

  logic              refclk = 1'b0;
  logic              resetn = 1'b0;
  logic              droop_req = 1'b0;
  logic              pll_locked = 1'b0;
  logic              pll_resetn, pll_brake, locked, busy, fault;
  logic [DIVN_W-1:0] pll_divn;
  logic [7:0]        lol_count;

  pll_seq_if #(.DIVN_W(DIVN_W)) cfg_if ();

  pll_seq dut (
    .refclk     (refclk),
    .resetn     (resetn),
    .cfg        (cfg_if),
    .droop_req  (droop_req),
    .pll_locked (pll_locked),
    .pll_resetn (pll_resetn),
    .pll_brake  (pll_brake),
    .pll_divn   (pll_divn),
    .locked     (locked),
    .busy       (busy),
    .fault      (fault),
    .lol_count  (lol_count)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a phase name plus time spent in it, counted upward.
  localparam int M_HOLD = 0, M_WAIT = 1, M_LOCK = 2, M_RAMP = 3, M_BRAKE = 4, M_FAULT = 5;
  int m_phase, m_elapsed, m_run, m_tries, m_divn, m_target, m_lol, m_prev_droop;

  function automatic int clamp_min(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  task automatic model_reset();
    m_phase = M_HOLD; m_elapsed = 0; m_run = 0; m_tries = 0;
    m_divn = 10; m_target = 10; m_lol = 0; m_prev_droop = 0;
  endtask

  function automatic bit model_ready(input bit rise);
    return (m_phase == M_LOCK || m_phase == M_FAULT) && !rise;
  endfunction

  task automatic enter_wait();
    m_phase = M_WAIT; m_elapsed = 0; m_run = 0;
  endtask

  task automatic model_step();
    bit rise, take;
    int t, gap;
    rise = droop_req && !m_prev_droop;
    take = cfg_if.cfg_valid && model_ready(rise);
    case (m_phase)
      M_HOLD: begin
        m_elapsed++;
        if (m_elapsed == 8) enter_wait();
      end
      M_WAIT: begin
        m_run = pll_locked ? m_run + 1 : 0;
        if (m_run == 16) begin
          m_phase = M_LOCK; m_tries = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == 4096) begin
            m_tries++;
            m_elapsed = 0;
            m_phase = (m_tries < 3) ? M_HOLD : M_FAULT;
          end
        end
      end
      M_LOCK: begin
        if (rise) begin
          m_phase = M_BRAKE; m_elapsed = 0;
        end else if (!pll_locked) begin
          m_lol = (m_lol + 1 > 255) ? 255 : m_lol + 1;
          enter_wait();
        end else if (take) begin
          t = clamp_min(int'(cfg_if.cfg_divn));
          m_target = t;
          if (t != m_divn) begin
            m_phase = M_RAMP; m_elapsed = 0;
          end
        end
      end
      M_RAMP: begin
        if (rise) begin
          m_phase = M_BRAKE; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == 32) begin
            m_elapsed = 0;
            gap = (m_target > m_divn) ? m_target - m_divn : m_divn - m_target;
            if (gap > 1) gap = 1;
            m_divn = (m_target > m_divn) ? m_divn + gap : m_divn - gap;
            if (m_divn == m_target) enter_wait();
          end
        end
      end
      M_BRAKE: begin
        m_elapsed++;
        if (m_elapsed == 4) enter_wait();
      end
      M_FAULT: begin
        if (take) begin
          m_divn = clamp_min(int'(cfg_if.cfg_divn));
          m_tries = 0; m_phase = M_HOLD; m_elapsed = 0;
        end
      end
      default: m_phase = M_HOLD;
    endcase
    m_prev_droop = droop_req;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge refclk);
      check("pll_resetn", int'(pll_resetn), (m_phase == M_HOLD || m_phase == M_FAULT) ? 0 : 1);
      check("pll_brake", int'(pll_brake), (m_phase == M_BRAKE) ? 1 : 0);
      check("pll_divn", int'(pll_divn), m_divn);
      check("locked", int'(locked), (m_phase == M_LOCK) ? 1 : 0);
      check("busy", int'(busy), (m_phase == M_LOCK || m_phase == M_FAULT) ? 0 : 1);
      check("fault", int'(fault), (m_phase == M_FAULT) ? 1 : 0);
      check("lol_count", int'(lol_count), m_lol);
      check("cfg_ready", int'(cfg_if.cfg_ready),
            int'(model_ready(droop_req && !m_prev_droop)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_locked(input string name, input int budget);
    int k = 0;
    while (!locked && k < budget) begin
      tick(1);
      k++;
    end
    check(name, int'(locked), 1);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_divn  = '0;

    // Power-up with pll_locked high as soon as reset is released.
    tick(3);
    check("rst_divn", int'(pll_divn), 10);
    check("rst_busy", int'(busy), 1);
    resetn = 1'b1;
    pll_locked = 1'b1;
    tick(7);
    check("hold_7", int'(pll_resetn), 0);
    tick(1);
    check("hold_8", int'(pll_resetn), 1);
    tick(15);
    check("lock_23", int'(locked), 0);
    tick(1);
    check("lock_24", int'(locked), 1);
    check("lock_busy", int'(busy), 0);

    // Ramp 10 -> 14, one step every 32 cycles.
    cfg_if.cfg_divn = 16'd14; cfg_if.cfg_valid = 1'b1;
    #1 check("ready_locked", int'(cfg_if.cfg_ready), 1);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    check("ready_ramp", int'(cfg_if.cfg_ready), 0);
    tick(31);
    check("ramp_31", int'(pll_divn), 10);
    tick(1);
    check("ramp_32", int'(pll_divn), 11);
    for (int v = 12; v <= 14; v++) begin
      tick(32);
      check("ramp_step", int'(pll_divn), v);
    end
    check("ramp_done_busy", int'(busy), 1);
    tick(15);
    check("relock_15", int'(locked), 0);
    tick(1);
    check("relock_16", int'(locked), 1);

    // Request below the clamp ramps down to 4.
    cfg_if.cfg_divn = 16'd2; cfg_if.cfg_valid = 1'b1;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    wait_locked("clamp_lock", 400);
    check("clamp_divn", int'(pll_divn), 4);

    // Droop during a ramp at divn 12: brake exactly 4 cycles, divn held.
    cfg_if.cfg_divn = 16'd14; cfg_if.cfg_valid = 1'b1;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    tick(256);
    check("pre_droop_divn", int'(pll_divn), 12);
    tick(5);
    droop_req = 1'b1;
    tick(1);
    check("brake_on", int'(pll_brake), 1);
    check("brake_divn", int'(pll_divn), 12);
    droop_req = 1'b0;
    tick(1);
    droop_req = 1'b1;
    tick(2);
    check("brake_3", int'(pll_brake), 1);
    tick(1);
    check("brake_off", int'(pll_brake), 0);
    droop_req = 1'b0;
    wait_locked("brake_relock", 40);
    check("brake_keep_divn", int'(pll_divn), 12);

    // Droop in LOCKED beats a simultaneous retarget.
    cfg_if.cfg_divn = 16'd20; cfg_if.cfg_valid = 1'b1; droop_req = 1'b1;
    #1 check("ready_droop", int'(cfg_if.cfg_ready), 0);
    tick(1);
    cfg_if.cfg_valid = 1'b0; droop_req = 1'b0;
    check("locked_brake", int'(pll_brake), 1);
    wait_locked("droop_relock", 40);
    check("droop_divn", int'(pll_divn), 12);

    // 300 one-cycle lock losses: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      if (i == 0) begin
        check("lol_first", int'(lol_count), 1);
        check("lol_drop", int'(locked), 0);
      end
      tick(16);
    end
    check("lol_sat", int'(lol_count), 255);
    check("lol_locked", int'(locked), 1);

    // Lock never arrives: three attempts of 8 + 4096 cycles, then FAULT.
    resetn = 1'b0; pll_locked = 1'b0;
    tick(2);
    check("rst_lol", int'(lol_count), 0);
    resetn = 1'b1;
    tick(8);
    check("try1_resetn", int'(pll_resetn), 1);
    tick(12303);
    check("pre_fault", int'(fault), 0);
    tick(1);
    check("fault", int'(fault), 1);
    check("fault_resetn", int'(pll_resetn), 0);
    check("fault_busy", int'(busy), 0);
    cfg_if.cfg_divn = 16'd20; cfg_if.cfg_valid = 1'b1;
    #1 check("fault_ready", int'(cfg_if.cfg_ready), 1);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    check("fault_divn", int'(pll_divn), 20);
    check("fault_clear", int'(fault), 0);
    pll_locked = 1'b1;
    tick(23);
    check("rebring_23", int'(locked), 0);
    tick(1);
    check("rebring_24", int'(locked), 1);

    // Async reset mid-ramp: outputs return before the next refclk edge.
    cfg_if.cfg_divn = 16'd30; cfg_if.cfg_valid = 1'b1;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    tick(40);
    check("mid_ramp_divn", int'(pll_divn), 21);
    #2 resetn = 1'b0;
    #1;
    check("async_divn", int'(pll_divn), 10);
    check("async_resetn", int'(pll_resetn), 0);
    check("async_busy", int'(busy), 1);
    check("async_locked", int'(locked), 0);
    tick(3);
    resetn = 1'b1;
    wait_locked("final_lock", 40);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
